// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way bus arbiter.
//   arb_state_t : arbiter FSM state (no owner / bus owned)
//   rr_result_t : picker result (found flag + winning index)
//   rr_next()   : round-robin search of req from prio, skipping excluded bits
//   onehot4()   : 2-bit index to 4-bit one-hot
package arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic {IDLE, OWNED} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_result_t;

  // Search order is prio, prio+1, ... mod 4. Walking from the lowest priority
  // offset up to offset 0 lets the last hit be the highest-priority one.
  function automatic rr_result_t rr_next(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       prio,
                                         input logic [N_REQ-1:0] exclude);
    rr_result_t       res;
    logic [N_REQ-1:0] cand;
    logic [1:0]       idx;
    res.found = 1'b0;
    res.idx   = 2'd0;
    cand      = req & ~exclude;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = prio + 2'(i);
      if (cand[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker with an exclude mask.
//   i_req     : request vector
//   i_prio    : index with highest priority
//   i_exclude : bits that may not win (e.g. the current owner)
//   o_found   : some eligible request exists
//   o_idx     : winning index (valid when o_found)
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_prio,
  input  logic [N_REQ-1:0] i_exclude,
  output logic             o_found,
  output logic [1:0]       o_idx
);

  rr_result_t w_res;

  assign w_res   = rr_next(i_req, i_prio, i_exclude);
  assign o_found = w_res.found;
  assign o_idx   = w_res.idx;

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for the shared 8-bit operand/result bus. Drives the
// select line of the 4-to-1 byte mux on behalf of four requesters.
//   i_clk          : rising-edge clock
//   i_rst_n        : synchronous active-low reset
//   i_req          : per-requester request, bit i = requester i
//   o_grant        : registered one-hot owner, zero when idle
//   o_select       : encoded owner for the mux; holds last value when idle
//   o_bus_valid    : bus currently owned
//   o_hold_expired : one-cycle pulse when a forced rotation takes effect
// MAX_HOLD (2..255) bounds consecutive ownership while others wait.
module bus_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic [1:0]       o_select,
  output logic             o_bus_valid,
  output logic             o_hold_expired
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  arb_state_t       r_state;
  logic [1:0]       r_own;
  logic [1:0]       r_prio;
  logic [7:0]       r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic [1:0]       r_select;
  logic             r_bus_valid;
  logic             r_hold_expired;

  logic [N_REQ-1:0] w_exclude;
  logic             w_found;
  logic [1:0]       w_idx;

  // The owner never competes against the others when re-arbitrating, so one
  // picker serves idle arbitration, release handover and forced rotation.
  assign w_exclude = (r_state == OWNED) ? onehot4(r_own) : '0;

  rr_pick4 u_pick (
    .i_req     (i_req),
    .i_prio    (r_prio),
    .i_exclude (w_exclude),
    .o_found   (w_found),
    .o_idx     (w_idx)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_own          <= 2'd0;
      r_prio         <= 2'd0;
      r_cnt          <= 8'd0;
      r_grant        <= '0;
      r_select       <= 2'd0;
      r_bus_valid    <= 1'b0;
      r_hold_expired <= 1'b0;
    end else begin
      r_hold_expired <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state     <= OWNED;
            r_own       <= w_idx;
            r_cnt       <= 8'd0;
            r_prio      <= w_idx + 2'd1;
            r_grant     <= onehot4(w_idx);
            r_select    <= w_idx;
            r_bus_valid <= 1'b1;
          end
        end
        OWNED: begin
          if (i_req[r_own]) begin
            if (r_cnt == HoldLast) begin
              // At the limit: rotate only if someone else waits, else saturate.
              if (w_found) begin
                r_own          <= w_idx;
                r_cnt          <= 8'd0;
                r_prio         <= w_idx + 2'd1;
                r_grant        <= onehot4(w_idx);
                r_select       <= w_idx;
                r_hold_expired <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (w_found) begin
            // Release handover with no idle gap.
            r_own    <= w_idx;
            r_cnt    <= 8'd0;
            r_prio   <= w_idx + 2'd1;
            r_grant  <= onehot4(w_idx);
            r_select <= w_idx;
          end else begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_grant     <= '0;
            r_bus_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant        = r_grant;
  assign o_select       = r_select;
  assign o_bus_valid    = r_bus_valid;
  assign o_hold_expired = r_hold_expired;

endmodule
